// File: rtl/dmem_pkg.sv
// Shared encodings and constants for the data-memory responder and its lane aligner.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Wide enough to hold LATENCY-1 for the largest legal LATENCY (15).
    localparam int LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the MEM stage (master) and the data memory (slave).
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for a 32-bit word: store merge, load extract/extend, alignment check.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_old_word,
    output logic [31:0] o_store_word,
    output logic [31:0] o_load_data,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_old_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_old_word[31:16] : i_old_word[15:0];

    // Illegal size leaves the word untouched and returns zero; the caller flags it.
    always_comb begin
        o_store_word = i_old_word;
        o_load_data  = '0;
        o_misalign   = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_store_word[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
                o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_misalign = i_addr_lo[0];
                if (i_addr_lo[1]) begin
                    o_store_word[31:16] = i_wdata[15:0];
                end else begin
                    o_store_word[15:0] = i_wdata[15:0];
                end
                o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                o_misalign   = |i_addr_lo;
                o_store_word = i_wdata;
                o_load_data  = i_old_word;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Word-organised data RAM with configurable latency behind a valid/ready request/response port.
// Optional build macro DMEM_PERF_CNT_EN adds load/store/error event counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    dmem_responder_if.slave bus
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0]     cnt_loads,
    output logic [31:0]     cnt_stores,
    output logic [31:0]     cnt_errs
`endif
);

    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    logic [31:0]    r_mem [DEPTH];

    dmem_state_t    r_state;
    logic [LAT_CNT_W-1:0] r_cnt;
    logic           r_req_ready;
    logic           r_rsp_valid;
    logic [31:0]    r_rsp_rdata;
    logic           r_rsp_err;

    logic           r_we;
    logic [31:0]    r_addr;
    logic [1:0]     r_size;
    logic           r_unsigned;
    logic [31:0]    r_wdata;

    logic           w_accept;
    logic           w_enter_resp;
    logic           w_we;
    logic [31:0]    w_addr;
    logic [1:0]     w_size;
    logic           w_unsigned;
    logic [31:0]    w_wdata;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]    w_old_word;
    logic [31:0]    w_store_word;
    logic [31:0]    w_load_data;
    logic           w_misalign;
    logic           w_in_range;
    logic           w_err;
    logic           w_commit;

    assign w_accept     = bus.req_valid && r_req_ready;
    assign w_enter_resp = ((r_state == WAIT) && (r_cnt == '0)) || (w_accept && (LATENCY == 1));

    // With single-cycle latency the access resolves on the accept edge, before the latch holds it.
    assign w_we       = (LATENCY == 1) ? bus.req_we       : r_we;
    assign w_addr     = (LATENCY == 1) ? bus.req_addr     : r_addr;
    assign w_size     = (LATENCY == 1) ? bus.req_size     : r_size;
    assign w_unsigned = (LATENCY == 1) ? bus.req_unsigned : r_unsigned;
    assign w_wdata    = (LATENCY == 1) ? bus.req_wdata    : r_wdata;

    assign w_idx      = w_addr[IDX_W+1:2];
    assign w_old_word = r_mem[w_idx];
    assign w_in_range = (w_addr[31:2] < DEPTH_W);
    assign w_err      = w_misalign || (w_size == 2'b11) || !w_in_range;
    assign w_commit   = w_enter_resp && w_we && !w_err;

    dmem_lane_align u_lane_align (
        .i_addr_lo    (w_addr[1:0]),
        .i_size       (w_size),
        .i_unsigned   (w_unsigned),
        .i_wdata      (w_wdata),
        .i_old_word   (w_old_word),
        .o_store_word (w_store_word),
        .o_load_data  (w_load_data),
        .o_misalign   (w_misalign)
    );

    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_idx] <= w_store_word;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we       <= bus.req_we;
            r_addr     <= bus.req_addr;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_wdata    <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_cnt       <= LAT_CNT_W'(LATENCY - 1);
                        r_state     <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b0;
                end
            endcase
            if (w_enter_resp) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_we || w_err) ? 32'd0 : w_load_data;
            end
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] r_cnt_loads;
    logic [31:0] r_cnt_stores;
    logic [31:0] r_cnt_errs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt_loads  <= '0;
            r_cnt_stores <= '0;
            r_cnt_errs   <= '0;
        end else if (w_enter_resp) begin
            if (w_err) begin
                r_cnt_errs <= r_cnt_errs + 32'd1;
            end else if (w_we) begin
                r_cnt_stores <= r_cnt_stores + 32'd1;
            end else begin
                r_cnt_loads <= r_cnt_loads + 32'd1;
            end
        end
    end

    assign cnt_loads  = r_cnt_loads;
    assign cnt_stores = r_cnt_stores;
    assign cnt_errs   = r_cnt_errs;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus randomized accesses vs a byte-array model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if bus();

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] cnt_loads, cnt_stores, cnt_errs;
    int exp_loads = 0, exp_stores = 0, exp_errs = 0;
`endif

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef DMEM_PERF_CNT_EN
        ,
        .cnt_loads  (cnt_loads),
        .cnt_stores (cnt_stores),
        .cnt_errs   (cnt_errs)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Byte-addressed shadow of the first 16 words (addresses 0x00..0x3F).
    bit [7:0] mem_b [64];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_access(input bit we, input bit [31:0] addr, input bit [1:0] size,
                                       input bit uns, input bit [31:0] wdata,
                                       output bit err, output bit [31:0] rdata);
        int nbytes;
        bit [31:0] v;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        rdata  = 32'd0;
        err    = (size == 2'd3) || ((addr % nbytes) != 0) || ((addr >> 2) >= DEPTH);
        if (err) return;
        if (we) begin
            for (int b = 0; b < nbytes; b++) mem_b[addr + b] = 8'((wdata >> (8 * b)) & 32'hFF);
        end else begin
            v = 32'd0;
            for (int b = 0; b < nbytes; b++) v = v | (32'(mem_b[addr + b]) << (8 * b));
            if (!uns && nbytes < 4 && v[8 * nbytes - 1]) v = v | (32'hFFFFFFFF << (8 * nbytes));
            rdata = v;
        end
    endfunction

    // One complete transaction; 'hold' cycles of rsp_ready=0 with a stray request presented meanwhile.
    task automatic do_txn(input bit we, input bit [31:0] addr, input bit [1:0] size, input bit uns,
                          input bit [31:0] wdata, input int hold, input string tag,
                          output logic [31:0] got_rdata, output logic got_err);
        bit exp_err;
        bit [31:0] exp_rdata;
        int waited;
        ref_access(we, addr, size, uns, wdata, exp_err, exp_rdata);
`ifdef DMEM_PERF_CNT_EN
        if (exp_err) exp_errs++; else if (we) exp_stores++; else exp_loads++;
`endif
        @(negedge clk);
        bus.req_valid = 1'b1;  bus.req_we = we;  bus.req_addr = addr;
        bus.req_size  = size;  bus.req_unsigned = uns;  bus.req_wdata = wdata;
        bus.rsp_ready = 1'b0;
        waited = 0;
        while (bus.req_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) check_eq({tag, ".accept_timeout"}, 32'(waited), 0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        // Accept edge closes cycle T; the response occupies cycle T+LATENCY.
        waited = 0;
        while (bus.rsp_valid !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check_eq({tag, ".latency"}, 32'(waited), LATENCY);
        check_eq({tag, ".rdata"}, bus.rsp_rdata, exp_rdata);
        check_eq({tag, ".err"}, 32'(bus.rsp_err), 32'(exp_err));
        got_rdata = bus.rsp_rdata;
        got_err   = bus.rsp_err;
        for (int k = 0; k < hold; k++) begin
            bus.req_valid = 1'b1;  bus.req_we = 1'b1;  bus.req_addr = 32'h0;
            bus.req_size  = SZ_WORD;  bus.req_wdata = 32'hBAD0BAD0;
            @(posedge clk);
            #1;
            check_eq({tag, ".hold_vld_rdy_err"}, 32'({bus.rsp_valid, bus.req_ready, bus.rsp_err}),
                     32'({1'b1, 1'b0, exp_err}));
            check_eq({tag, ".hold_rdata"}, bus.rsp_rdata, exp_rdata);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check_eq({tag, ".post_vld_err_rdy"}, 32'({bus.rsp_valid, bus.rsp_err, bus.req_ready}),
                 32'({1'b0, 1'b0, 1'b1}));
        check_eq({tag, ".post_rdata"}, bus.rsp_rdata, 32'd0);
`ifdef DMEM_PERF_CNT_EN
        check_eq({tag, ".cnt_loads"}, cnt_loads, 32'(exp_loads));
        check_eq({tag, ".cnt_stores"}, cnt_stores, 32'(exp_stores));
        check_eq({tag, ".cnt_errs"}, cnt_errs, 32'(exp_errs));
`endif
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        bit [31:0]   a;
        bit [1:0]    sz;
        bus.req_valid = 1'b0;  bus.req_we = 1'b0;  bus.req_addr = '0;
        bus.req_size  = '0;    bus.req_unsigned = 1'b0;  bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("reset.outputs", 32'({bus.req_ready, bus.rsp_valid, bus.rsp_err}), 0);
        check_eq("reset.rdata", bus.rsp_rdata, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("reset.ready_after_release", 32'(bus.req_ready), 1);

        for (int w = 0; w < 16; w++) do_txn(1'b1, 32'(w * 4), SZ_WORD, 1'b0, $urandom, 0, "init", rd, er);

        do_txn(1'b1, 32'h10, SZ_WORD, 1'b0, 32'hDEADBEEF, 0, "st_w10", rd, er);
        do_txn(1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, 0, "ld_w10", rd, er);
        check_eq("ld_w10.const", rd, 32'hDEADBEEF);
        do_txn(1'b0, 32'h13, SZ_BYTE, 1'b0, 32'h0, 0, "ld_b13s", rd, er);
        check_eq("ld_b13s.const", rd, 32'hFFFFFFDE);
        do_txn(1'b0, 32'h13, SZ_BYTE, 1'b1, 32'h0, 0, "ld_b13u", rd, er);
        check_eq("ld_b13u.const", rd, 32'h000000DE);
        do_txn(1'b0, 32'h12, SZ_HALF, 1'b0, 32'h0, 0, "ld_h12s", rd, er);
        check_eq("ld_h12s.const", rd, 32'hFFFFDEAD);
        do_txn(1'b1, 32'h11, SZ_BYTE, 1'b0, 32'h55, 0, "st_b11", rd, er);
        do_txn(1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, 0, "ld_w10b", rd, er);
        check_eq("ld_w10b.const", rd, 32'hDEAD55EF);
        do_txn(1'b0, 32'h11, SZ_HALF, 1'b0, 32'h0, 0, "ld_h11_misalign", rd, er);
        check_eq("ld_h11_misalign.const_err", 32'(er), 1);
        do_txn(1'b1, 32'h1000, SZ_WORD, 1'b0, 32'h12345678, 0, "st_oor", rd, er);
        check_eq("st_oor.const_err", 32'(er), 1);
        do_txn(1'b1, 32'h10, 2'b11, 1'b0, 32'h0, 0, "st_illegal_size", rd, er);
        do_txn(1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, 5, "ld_w10_hold", rd, er);
        check_eq("ld_w10_hold.const", rd, 32'hDEAD55EF);

        // Store aborted by reset while waiting must leave the earlier contents in place.
        do_txn(1'b1, 32'h20, SZ_WORD, 1'b0, 32'hCAFEF00D, 0, "st_w20", rd, er);
        @(negedge clk);
        bus.req_valid = 1'b1;  bus.req_we = 1'b1;  bus.req_addr = 32'h20;
        bus.req_size  = SZ_WORD;  bus.req_wdata = 32'h0BADBEEF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("midreset.outputs", 32'({bus.req_ready, bus.rsp_valid, bus.rsp_err}), 0);
        check_eq("midreset.rdata", bus.rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
`ifdef DMEM_PERF_CNT_EN
        check_eq("midreset.cnt_sum", cnt_loads + cnt_stores + cnt_errs, 32'd0);
        exp_loads = 0;  exp_stores = 0;  exp_errs = 0;
`endif
        @(posedge clk);
        #1;
        check_eq("midreset.ready", 32'(bus.req_ready), 1);
        do_txn(1'b0, 32'h20, SZ_WORD, 1'b0, 32'h0, 0, "ld_w20", rd, er);
        check_eq("ld_w20.const", rd, 32'hCAFEF00D);

        for (int i = 0; i < 200; i++) begin
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) sz = ($urandom_range(0, 1) == 0) ? 2'b11 : SZ_WORD;
            if ($urandom_range(0, 9) == 0) a = 32'h1000 + $urandom_range(0, 32'h0FFF_FFFF);
            else a = 32'($urandom_range(0, 63));
            do_txn(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom,
                   $urandom_range(0, 3), "rand", rd, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
